// File: rtl/div_pkg.sv
// Shared widths and result-field layout for the divider instances.
package div_pkg;

  localparam int unsigned DIVIDEND_W_DEF = 32;
  localparam int unsigned DIVISOR_W_DEF  = 24;

  // Result bus layout: {quotient, remainder}
  localparam int unsigned QUO_LSB = DIVISOR_W_DEF;
  localparam int unsigned REM_LSB = 0;

  // Quotient field offset for a given remainder width
  function automatic int unsigned quo_lsb(input int unsigned divisor_w);
    return divisor_w;
  endfunction

endpackage

// File: rtl/div_gen_axis_if.sv
// AXI4-Stream dividend/divisor/result channels of the divider.
interface div_gen_axis_if #(
  parameter int unsigned DIVIDEND_W = div_pkg::DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = div_pkg::DIVISOR_W_DEF
) ();

  localparam int unsigned OUT_W = DIVIDEND_W + DIVISOR_W;

  logic                  s_axis_divisor_tvalid;
  logic                  s_axis_divisor_tready;
  logic [DIVISOR_W-1:0]  s_axis_divisor_tdata;
  logic                  s_axis_dividend_tvalid;
  logic                  s_axis_dividend_tready;
  logic [DIVIDEND_W-1:0] s_axis_dividend_tdata;
  logic                  m_axis_dout_tvalid;
  logic [OUT_W-1:0]      m_axis_dout_tdata;
  logic                  m_axis_dout_tuser;

  // Divider side
  modport slave (
    input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
    output s_axis_divisor_tready, s_axis_dividend_tready,
    output m_axis_dout_tvalid, m_axis_dout_tdata, m_axis_dout_tuser
  );

  // Operand source / result sink side
  modport master (
    output s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tvalid, s_axis_dividend_tdata,
    input  s_axis_divisor_tready, s_axis_dividend_tready,
    input  m_axis_dout_tvalid, m_axis_dout_tdata, m_axis_dout_tuser
  );

endinterface

// File: rtl/div_stage.sv
// One registered radix-2 restoring division step on unsigned magnitudes.
module div_stage #(
  parameter int unsigned DIVIDEND_W = div_pkg::DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = div_pkg::DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DIVIDEND_W-1:0] in_qa,
  input  logic [DIVISOR_W-1:0]  in_r,
  input  logic [DIVISOR_W-1:0]  in_b,
  input  logic                  in_neg_q,
  input  logic                  in_neg_r,
  input  logic                  in_dz,
  output logic                  out_valid,
  output logic [DIVIDEND_W-1:0] out_qa,
  output logic [DIVISOR_W-1:0]  out_r,
  output logic [DIVISOR_W-1:0]  out_b,
  output logic                  out_neg_q,
  output logic                  out_neg_r,
  output logic                  out_dz
);

  // qa holds the unconsumed dividend bits on top and the quotient bits
  // collected so far at the bottom; it shifts left one bit per stage.
  logic [DIVISOR_W:0]    shifted_c;
  logic                  ge_c;
  logic [DIVISOR_W-1:0]  r_next_c;
  logic [DIVIDEND_W-1:0] qa_next_c;

  // Shift in next dividend bit, trial-subtract divisor, pick quotient bit
  always_comb begin
    shifted_c = {in_r, in_qa[DIVIDEND_W-1]};
    ge_c      = (shifted_c >= {1'b0, in_b});
    // When ge_c is set the difference is below the divisor, so the low
    // DIVISOR_W bits hold it exactly.
    r_next_c  = ge_c ? (shifted_c[DIVISOR_W-1:0] - in_b) : shifted_c[DIVISOR_W-1:0];
    qa_next_c = {in_qa[DIVIDEND_W-2:0], ge_c};
  end

  // Valid bit, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
    end
  end

  // Data path, not reset
  always_ff @(posedge clk) begin
    if (en) begin
      out_qa    <= qa_next_c;
      out_r     <= r_next_c;
      out_b     <= in_b;
      out_neg_q <= in_neg_q;
      out_neg_r <= in_neg_r;
      out_dz    <= in_dz;
    end
  end

endmodule

// File: rtl/div_gen_axis.sv
// Fully pipelined integer divider with AXI4-Stream operand and result channels.
module div_gen_axis #(
  parameter int unsigned DIVIDEND_W = div_pkg::DIVIDEND_W_DEF,
  parameter int unsigned DIVISOR_W  = div_pkg::DIVISOR_W_DEF,
  parameter bit          SIGNED     = 1'b1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          aclken,
  div_gen_axis_if.slave axis
);

  import div_pkg::*;

  localparam int unsigned OUT_W = DIVIDEND_W + DIVISOR_W;
  localparam int unsigned N     = DIVIDEND_W;
  localparam int unsigned Q_LSB = quo_lsb(DIVISOR_W);

  logic                  rdy;
  logic                  launch_c;
  logic                  a_neg_c;
  logic                  b_neg_c;
  logic [N-1:0]          a_mag_c;
  logic [DIVISOR_W-1:0]  b_mag_c;

  logic                  in_valid;
  logic [N-1:0]          in_qa;
  logic [DIVISOR_W-1:0]  in_b;
  logic                  in_neg_q;
  logic                  in_neg_r;
  logic                  in_dz;

  // Pipeline taps: index 0 is the input register, index N the last stage
  logic                  v_p     [0:N];
  logic [N-1:0]          qa_p    [0:N];
  logic [DIVISOR_W-1:0]  r_p     [0:N];
  logic [DIVISOR_W-1:0]  b_p     [0:N];
  logic                  nq_p    [0:N];
  logic                  nr_p    [0:N];
  logic                  dz_p    [0:N];

  logic [N-1:0]          q_c;
  logic [DIVISOR_W-1:0]  rem_c;
  logic [OUT_W-1:0]      res_c;

  logic                  dout_valid;
  logic [OUT_W-1:0]      dout_data;
  logic                  dout_user;

  // Ready goes high on the first clock after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy <= 1'b0;
    end else begin
      rdy <= 1'b1;
    end
  end

  assign axis.s_axis_divisor_tready  = rdy;
  assign axis.s_axis_dividend_tready = rdy;

  // Launch condition and operand magnitudes
  always_comb begin
    launch_c = rdy & axis.s_axis_divisor_tvalid & axis.s_axis_dividend_tvalid;
    a_neg_c  = SIGNED & axis.s_axis_dividend_tdata[N-1];
    b_neg_c  = SIGNED & axis.s_axis_divisor_tdata[DIVISOR_W-1];
    a_mag_c  = a_neg_c ? (~axis.s_axis_dividend_tdata + N'(1))
                       : axis.s_axis_dividend_tdata;
    b_mag_c  = b_neg_c ? (~axis.s_axis_divisor_tdata + DIVISOR_W'(1))
                       : axis.s_axis_divisor_tdata;
  end

  // Input register valid bit; a bubble enters when nothing launches
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_valid <= 1'b0;
    end else if (aclken) begin
      in_valid <= launch_c;
    end
  end

  // Input register data: magnitudes plus sign and divide-by-zero flags
  always_ff @(posedge aclk) begin
    if (aclken && launch_c) begin
      in_qa    <= a_mag_c;
      in_b     <= b_mag_c;
      in_neg_q <= a_neg_c ^ b_neg_c;
      in_neg_r <= a_neg_c;
      in_dz    <= (axis.s_axis_divisor_tdata == '0);
    end
  end

  assign v_p[0]  = in_valid;
  assign qa_p[0] = in_qa;
  assign r_p[0]  = '0;
  assign b_p[0]  = in_b;
  assign nq_p[0] = in_neg_q;
  assign nr_p[0] = in_neg_r;
  assign dz_p[0] = in_dz;

  // One restoring stage per dividend bit
  for (genvar i = 0; i < N; i++) begin : g_stage
    div_stage #(
      .DIVIDEND_W (DIVIDEND_W),
      .DIVISOR_W  (DIVISOR_W)
    ) u_stage (
      .clk       (aclk),
      .rst_n     (aresetn),
      .en        (aclken),
      .in_valid  (v_p[i]),
      .in_qa     (qa_p[i]),
      .in_r      (r_p[i]),
      .in_b      (b_p[i]),
      .in_neg_q  (nq_p[i]),
      .in_neg_r  (nr_p[i]),
      .in_dz     (dz_p[i]),
      .out_valid (v_p[i+1]),
      .out_qa    (qa_p[i+1]),
      .out_r     (r_p[i+1]),
      .out_b     (b_p[i+1]),
      .out_neg_q (nq_p[i+1]),
      .out_neg_r (nr_p[i+1]),
      .out_dz    (dz_p[i+1])
    );
  end

  // Sign restoration and result packing; zero divisor forces a zero result
  always_comb begin
    q_c   = nq_p[N] ? (~qa_p[N] + N'(1)) : qa_p[N];
    rem_c = nr_p[N] ? (~r_p[N] + DIVISOR_W'(1)) : r_p[N];
    if (dz_p[N]) begin
      q_c   = '0;
      rem_c = '0;
    end
    res_c = '0;
    res_c[Q_LSB +: N]           = q_c;
    res_c[REM_LSB +: DIVISOR_W] = rem_c;
  end

  // Output register; data only loads on valid beats so it reads 0 until the first result
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_user  <= 1'b0;
    end else if (aclken) begin
      dout_valid <= v_p[N];
      dout_user  <= v_p[N] & dz_p[N];
      if (v_p[N]) begin
        dout_data <= res_c;
      end
    end
  end

  assign axis.m_axis_dout_tvalid = dout_valid;
  assign axis.m_axis_dout_tdata  = dout_data;
  assign axis.m_axis_dout_tuser  = dout_user;

endmodule

// File: tb/tb_div_gen_axis.sv
// Directed and streaming checks for div_gen_axis in signed 32/24 and unsigned 28/9 builds.
module tb_div_gen_axis;

  typedef struct packed {
    logic [55:0] data;
    logic        user;
    int unsigned due;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic aclken = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 aclk = ~aclk;

  div_gen_axis_if #(.DIVIDEND_W(32), .DIVISOR_W(24)) sif ();
  div_gen_axis_if #(.DIVIDEND_W(28), .DIVISOR_W(9))  uif ();

  div_gen_axis #(.DIVIDEND_W(32), .DIVISOR_W(24), .SIGNED(1'b1)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .aclken  (aclken),
    .axis    (sif)
  );

  div_gen_axis #(.DIVIDEND_W(28), .DIVISOR_W(9), .SIGNED(1'b0)) u_dut_u (
    .aclk    (aclk),
    .aresetn (aresetn),
    .aclken  (aclken),
    .axis    (uif)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference: language signed division truncates toward zero, remainder takes dividend sign
  function automatic logic [56:0] model_s(input logic [31:0] a, input logic [23:0] b);
    longint sa, sb, q, r;
    logic [63:0] qb, rb;
    if (b == 24'd0) return {1'b1, 56'd0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    qb = q;
    rb = r;
    return {1'b0, qb[31:0], rb[23:0]};
  endfunction

  task automatic run_signed(input string tag, input logic [31:0] a, input logic [23:0] b,
                            input logic [31:0] eq, input logic [23:0] er, input logic eu);
    sif.s_axis_dividend_tdata  = a;
    sif.s_axis_divisor_tdata   = b;
    sif.s_axis_dividend_tvalid = 1'b1;
    sif.s_axis_divisor_tvalid  = 1'b1;
    step();
    sif.s_axis_dividend_tvalid = 1'b0;
    sif.s_axis_divisor_tvalid  = 1'b0;
    repeat (32) step();
    chk({tag, "_early"}, 64'(sif.m_axis_dout_tvalid), 64'd0);
    step();
    chk({tag, "_valid"}, 64'(sif.m_axis_dout_tvalid), 64'd1);
    chk({tag, "_q"}, 64'(sif.m_axis_dout_tdata[55:24]), 64'(eq));
    chk({tag, "_r"}, 64'(sif.m_axis_dout_tdata[23:0]), 64'(er));
    chk({tag, "_user"}, 64'(sif.m_axis_dout_tuser), 64'(eu));
    step();
    chk({tag, "_single"}, 64'(sif.m_axis_dout_tvalid), 64'd0);
  endtask

  initial begin
    exp_t        sq[$];
    exp_t        e;
    logic [56:0] m;
    logic [31:0] a;
    logic [23:0] b;
    logic        en, expv, pv, pu;
    logic [55:0] pd;
    int unsigned ecnt;
    int          launched, steps;

    sif.s_axis_dividend_tvalid = 1'b0;
    sif.s_axis_divisor_tvalid  = 1'b0;
    sif.s_axis_dividend_tdata  = '0;
    sif.s_axis_divisor_tdata   = '0;
    uif.s_axis_dividend_tvalid = 1'b0;
    uif.s_axis_divisor_tvalid  = 1'b0;
    uif.s_axis_dividend_tdata  = '0;
    uif.s_axis_divisor_tdata   = '0;
    aclken = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_tready_dvd", 64'(sif.s_axis_dividend_tready), 64'd0);
    chk("rst_tready_dvs", 64'(sif.s_axis_divisor_tready), 64'd0);
    chk("rst_tvalid", 64'(sif.m_axis_dout_tvalid), 64'd0);
    chk("rst_tdata", 64'(sif.m_axis_dout_tdata), 64'd0);
    chk("rst_tuser", 64'(sif.m_axis_dout_tuser), 64'd0);
    aresetn = 1'b1;
    step();
    chk("tready_after_rst", 64'(sif.s_axis_dividend_tready & sif.s_axis_divisor_tready), 64'd1);
    chk("tready_after_rst_u", 64'(uif.s_axis_dividend_tready), 64'd1);

    // Directed signed vectors
    run_signed("basic",   32'd50_000_000, 24'd50_000,   32'd1000,       24'd0,        1'b0);
    run_signed("neg_pos", 32'hFFFF_FFEF,  24'd5,        32'hFFFF_FFFD,  24'hFF_FFFE,  1'b0);
    run_signed("pos_neg", 32'd17,         24'hFF_FFFB,  32'hFFFF_FFFD,  24'd2,        1'b0);
    run_signed("neg_neg", 32'hFFFF_FFEF,  24'hFF_FFFB,  32'd3,          24'hFF_FFFE,  1'b0);
    run_signed("div0",    32'd7,          24'd0,        32'd0,          24'd0,        1'b1);
    run_signed("ovf",     32'h8000_0000,  24'hFF_FFFF,  32'h8000_0000,  24'd0,        1'b0);
    run_signed("zero",    32'd0,          24'd123,      32'd0,          24'd0,        1'b0);

    // Unsigned 28/9 build: latency 30
    uif.s_axis_dividend_tdata  = 28'd100_000_000;
    uif.s_axis_divisor_tdata   = 9'd510;
    uif.s_axis_dividend_tvalid = 1'b1;
    uif.s_axis_divisor_tvalid  = 1'b1;
    step();
    uif.s_axis_dividend_tvalid = 1'b0;
    uif.s_axis_divisor_tvalid  = 1'b0;
    repeat (28) step();
    chk("uns_early", 64'(uif.m_axis_dout_tvalid), 64'd0);
    step();
    chk("uns_valid", 64'(uif.m_axis_dout_tvalid), 64'd1);
    chk("uns_q", 64'(uif.m_axis_dout_tdata[36:9]), 64'd196_078);
    chk("uns_r", 64'(uif.m_axis_dout_tdata[8:0]), 64'd220);
    chk("uns_user", 64'(uif.m_axis_dout_tuser), 64'd0);

    // Streaming with pseudo-random clock enable
    ecnt = 0;
    launched = 0;
    steps = 0;
    a = $urandom();
    b = 24'($urandom());
    while ((launched < 100 || sq.size() != 0) && steps < 3000) begin
      en = ($urandom_range(0, 3) != 0);
      aclken = en;
      sif.s_axis_dividend_tvalid = (launched < 100);
      sif.s_axis_divisor_tvalid  = (launched < 100);
      sif.s_axis_dividend_tdata  = a;
      sif.s_axis_divisor_tdata   = b;
      pv = sif.m_axis_dout_tvalid;
      pd = sif.m_axis_dout_tdata;
      pu = sif.m_axis_dout_tuser;
      step();
      steps++;
      if (en) begin
        ecnt++;
        if (launched < 100) begin
          m = model_s(a, b);
          e.data = m[55:0];
          e.user = m[56];
          e.due  = ecnt + 33;
          sq.push_back(e);
          launched++;
          a = $urandom();
          b = 24'($urandom());
        end
        expv = (sq.size() != 0) && (sq[0].due == ecnt);
        chk("strm_valid", 64'(sif.m_axis_dout_tvalid), 64'(expv));
        if (expv) begin
          chk("strm_data", 64'(sif.m_axis_dout_tdata), 64'(sq[0].data));
          chk("strm_user", 64'(sif.m_axis_dout_tuser), 64'(sq[0].user));
          void'(sq.pop_front());
        end
      end else begin
        chk("hold_valid", 64'(sif.m_axis_dout_tvalid), 64'(pv));
        chk("hold_data", 64'(sif.m_axis_dout_tdata), 64'(pd));
        chk("hold_user", 64'(sif.m_axis_dout_tuser), 64'(pu));
      end
    end
    chk("strm_drain", 64'(sq.size()), 64'd0);
    chk("strm_launched", 64'(launched), 64'd100);
    aclken = 1'b1;
    sif.s_axis_dividend_tvalid = 1'b0;
    sif.s_axis_divisor_tvalid  = 1'b0;

    // Reset while results are emerging and more are in flight
    for (int i = 0; i < 40; i++) begin
      sif.s_axis_dividend_tdata  = $urandom();
      sif.s_axis_divisor_tdata   = 24'($urandom_range(1, 1000));
      sif.s_axis_dividend_tvalid = 1'b1;
      sif.s_axis_divisor_tvalid  = 1'b1;
      step();
    end
    sif.s_axis_dividend_tvalid = 1'b0;
    sif.s_axis_divisor_tvalid  = 1'b0;
    chk("mid_pre_valid", 64'(sif.m_axis_dout_tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(sif.m_axis_dout_tvalid), 64'd0);
    chk("mid_rst_data", 64'(sif.m_axis_dout_tdata), 64'd0);
    chk("mid_rst_user", 64'(sif.m_axis_dout_tuser), 64'd0);
    chk("mid_rst_tready", 64'(sif.s_axis_dividend_tready | sif.s_axis_divisor_tready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_hold_valid", 64'(sif.m_axis_dout_tvalid), 64'd0);
      chk("mid_rst_hold_tready", 64'(sif.s_axis_dividend_tready), 64'd0);
    end
    aresetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("post_rst_no_stale", 64'(sif.m_axis_dout_tvalid), 64'd0);
    end
    chk("post_rst_tready", 64'(sif.s_axis_dividend_tready), 64'd1);
    run_signed("post_rst", 32'd1000, 24'd7, 32'd142, 24'd6, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
